ecc_dec_arb: RTL and testbench
==============================

// Module: ecc_dec_arb
// PURPOSE
//  Shares one (40,32) SEC-DED decode path between two requesters. Each requester presents a
//  40-bit codeword: data [31:0], check [38:32], spare [39]. Round-robin arbitration; 2-stage
//  pipeline (syndrome, then correct/classify). Corrected data goes out on a valid/ready port.
//  Saturating CE/UE event counters. Sits between the memory read mux and the consumer.
// PARAMETERS
//  CNT_W  16  width of ce_cnt/ue_cnt (saturating)
// PORTS
//  clk         in   1   clock; all state on rising edge
//  rst_n       in   1   async active-low reset
//  req0_valid  in   1   requester 0 codeword valid
//  req0_ready  out  1   requester 0 accepted this cycle (valid&ready = transfer)
//  req0_cw     in   40  requester 0 codeword
//  req1_valid  in   1   requester 1 codeword valid
//  req1_ready  out  1   requester 1 accepted this cycle
//  req1_cw     in   40  requester 1 codeword
//  out_valid   out  1   decoded result valid
//  out_ready   in   1   consumer accepts result
//  out_data    out  32  corrected data (raw data if UE)
//  out_spare   out  1   cw[39] passed through unchanged
//  out_src     out  1   requester index of this result
//  out_ce      out  1   single-bit error corrected
//  out_ue      out  1   uncorrectable error
//  out_syn     out  7   syndrome of this result
//  cnt_clr     in   1   sync clear of both counters
//  ce_cnt      out  CNT_W  corrected-event count
//  ue_cnt      out  CNT_W  uncorrectable-event count
// BEHAVIOUR
//  Reset: all pipeline valids 0, every output 0 (readys 0), rr pointer = req0, counters 0.
//  Reset mid-operation discards in-flight words; no partial output.
//  advance = !s2_valid | out_ready. The whole pipeline stalls when !advance.
//  Arbitration (comb.): if advance, grant one valid requester. If both are valid, grant the
//   rr pointer. The pointer moves to the other requester after each transfer where both were
//   valid. reqX_ready = grant_X & advance. Ready is never high while its requester is not valid.
//  S1 (register stage 1): latch cw and src. Syndrome syn[i] = XOR of data bits in H row i ^ cw[32+i].
//  S2 (register stage 2): class. syn==0 -> OK. syn equal to data column j -> flip data[j], CE.
//   syn one-hot -> check-bit error, data unchanged, CE. Any other value -> UE, data unchanged.
//  Latency: transfer in cycle N -> out_valid in cycle N+2 (no stall). Throughput 1 word/cycle.
//  Outputs are held stable while out_valid & !out_ready.
//  Counters increment once per output transfer with out_ce/out_ue. They saturate at all-ones.
//   cnt_clr takes priority: a coinciding event loads 1, otherwise the counter loads 0.
// CONFIGURATION
//  ECC_ERR_LOG_EN defined: adds outputs log_valid(1), log_src(1), log_ue(1), log_syn(7).
//   These capture the first CE/UE output transfer after reset or cnt_clr and stay sticky.
//   cnt_clr clears log_valid; an event coinciding with cnt_clr is captured.
//  ECC_ERR_LOG_EN undefined: those ports and registers do not exist; all else identical.
// STRUCTURE
//  Package ecc_pkg:
//   - CW_W=40, DATA_W=32, CHK_W=7
//   - H_COL[0:31] 7-bit data columns of the team's code (e.g. bit0=7'h07, bit9=7'h70)
//   - enum ecc_class_e {ECC_OK, ECC_CE, ECC_UE}
//   - function col_match returning hit + index
//  Sub-module ecc_syn_calc: combinational cw[38:0] -> syn[6:0] from H_COL. Instantiated in S1.
// TESTING
//  1 Clean word: req0_cw = {1'b1,7'h??(valid check),32'hDEADBEEF}, out_ready=1.
//    -> 2 cycles later out_data=DEADBEEF, out_spare=1, out_syn=0, ce=ue=0.
//  2 Flip data bit 0 of a valid cw. -> out_syn=7'h07, out_ce=1, data corrected, ce_cnt=1.
//    Then flip bit 9. -> syn=7'h70, ce_cnt=2.
//  3 Flip data bits 0 and 9 (syn=7'h77). -> out_ue=1, out_data = raw, ue_cnt=1.
//    Flip check bit 32 only. -> syn=7'h01, CE, data unchanged.
//  4 Both requesters valid 6 cycles. -> grants alternate 0,1,0,1,0,1; out_src matches in order.
//    Only req1 valid. -> req1 granted every cycle.
//  5 out_ready=0 for 5 cycles with both valid. -> at most 2 words in flight, readys low,
//    outputs held; on release words drain in order, none lost or duplicated.
//  6 Set ce_cnt to saturate at CNT_W=4 (16 CEs) -> stays 15. cnt_clr with a CE same cycle
//    -> ce_cnt=1. Assert rst_n=0 mid-stream -> outputs 0 next sample, no stale result after.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared constants, H-matrix data columns and helpers for the (40,32) SEC-DED decoder.
package ecc_pkg;

  localparam int unsigned CW_W   = 40;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CHK_W  = 7;

  // Odd-weight (weight-3) columns: any double error gives an even-weight syndrome,
  // which can never alias to a data column or a single check bit.
  localparam logic [CHK_W-1:0] H_COL [0:DATA_W-1] = '{
    7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
    7'h1A, 7'h70, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A,
    7'h2C, 7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46,
    7'h49, 7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61
  };

  typedef enum logic [1:0] {ECC_OK, ECC_CE, ECC_UE} ecc_class_e;

  typedef struct packed {
    logic       hit;
    logic [4:0] idx;
  } col_match_t;

  function automatic col_match_t col_match(input logic [CHK_W-1:0] syn);
    col_match_t m;
    m = '0;
    for (int unsigned j = 0; j < DATA_W; j++) begin
      if (!m.hit && syn == H_COL[j[4:0]]) begin
        m.hit = 1'b1;
        m.idx = j[4:0];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ecc_syn_calc.sv
// Combinational syndrome: XOR of the H columns of set data bits, folded with the stored check bits.
module ecc_syn_calc
  import ecc_pkg::*;
(
  input  logic [CW_W-2:0]  cw,
  output logic [CHK_W-1:0] syn
);

  logic [DATA_W-1:0] data;
  assign data = cw[DATA_W-1:0];

  always_comb begin
    syn = cw[DATA_W +: CHK_W];
    for (int unsigned j = 0; j < DATA_W; j++) begin
      if (data[j[4:0]]) syn = syn ^ H_COL[j[4:0]];
    end
  end

endmodule

// File: rtl/ecc_dec_arb.sv
// Two-requester round-robin front end to a 2-stage (40,32) SEC-DED decoder with CE/UE counters.
// Optional first-error log ports are enabled with `define ECC_ERR_LOG_EN.
module ecc_dec_arb
  import ecc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [CW_W-1:0]  req0_cw,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [CW_W-1:0]  req1_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic             out_spare,
  output logic             out_src,
  output logic             out_ce,
  output logic             out_ue,
  output logic [CHK_W-1:0] out_syn,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ce_cnt,
  output logic [CNT_W-1:0] ue_cnt
`ifdef ECC_ERR_LOG_EN
  ,
  output logic             log_valid,
  output logic             log_src,
  output logic             log_ue,
  output logic [CHK_W-1:0] log_syn
`endif
);

  logic advance, go, rr, grant0, grant1;
  logic s1_valid, s1_src;
  logic [CW_W-1:0] s1_cw;
  logic [CHK_W-1:0] s1_syn;
  col_match_t s1_match;
  ecc_class_e s1_cls;
  logic [DATA_W-1:0] s1_fix;
  logic s2_valid, s2_spare, s2_src, s2_ce, s2_ue;
  logic [DATA_W-1:0] s2_data;
  logic [CHK_W-1:0] s2_syn;
  logic xfer, ce_ev, ue_ev;

  assign advance = !s2_valid || out_ready;
  // Readys are also held low while reset is asserted.
  assign go      = advance && rst_n;
  assign grant0  = req0_valid && (!req1_valid || !rr);
  assign grant1  = req1_valid && (!req0_valid || rr);
  assign req0_ready = grant0 && go;
  assign req1_ready = grant1 && go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr       <= 1'b0;
      s1_valid <= 1'b0;
      s1_src   <= 1'b0;
      s1_cw    <= '0;
    end else if (advance) begin
      s1_valid <= grant0 || grant1;
      s1_src   <= grant1;
      s1_cw    <= grant1 ? req1_cw : req0_cw;
      if (req0_valid && req1_valid) rr <= !rr;
    end
  end

  ecc_syn_calc u_syn (
    .cw  (s1_cw[CW_W-2:0]),
    .syn (s1_syn)
  );

  always_comb begin
    s1_match = col_match(s1_syn);
    s1_fix   = s1_cw[DATA_W-1:0];
    s1_cls   = ECC_UE;
    if (s1_syn == '0) begin
      s1_cls = ECC_OK;
    end else if (s1_match.hit) begin
      s1_cls = ECC_CE;
      s1_fix[s1_match.idx] = ~s1_fix[s1_match.idx];
    end else if ($onehot(s1_syn)) begin
      s1_cls = ECC_CE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_spare <= 1'b0;
      s2_src   <= 1'b0;
      s2_ce    <= 1'b0;
      s2_ue    <= 1'b0;
      s2_syn   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_data  <= s1_fix;
      s2_spare <= s1_cw[CW_W-1];
      s2_src   <= s1_src;
      s2_ce    <= (s1_cls == ECC_CE);
      s2_ue    <= (s1_cls == ECC_UE);
      s2_syn   <= s1_syn;
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_spare = s2_spare;
  assign out_src   = s2_src;
  assign out_ce    = s2_ce;
  assign out_ue    = s2_ue;
  assign out_syn   = s2_syn;

  assign xfer  = s2_valid && out_ready;
  assign ce_ev = xfer && s2_ce;
  assign ue_ev = xfer && s2_ue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_cnt <= '0;
      ue_cnt <= '0;
    end else if (cnt_clr) begin
      ce_cnt <= CNT_W'(ce_ev);
      ue_cnt <= CNT_W'(ue_ev);
    end else begin
      if (ce_ev && ce_cnt != '1) ce_cnt <= ce_cnt + CNT_W'(1);
      if (ue_ev && ue_cnt != '1) ue_cnt <= ue_cnt + CNT_W'(1);
    end
  end

`ifdef ECC_ERR_LOG_EN
  logic log_ev;
  assign log_ev = ce_ev || ue_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_valid <= 1'b0;
      log_src   <= 1'b0;
      log_ue    <= 1'b0;
      log_syn   <= '0;
    end else if ((cnt_clr || !log_valid) && log_ev) begin
      log_valid <= 1'b1;
      log_src   <= s2_src;
      log_ue    <= s2_ue;
      log_syn   <= s2_syn;
    end else if (cnt_clr) begin
      log_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ecc_dec_arb.sv
// Scoreboard bench for ecc_dec_arb: directed codewords, queued expected results, negedge monitor.
module tb_ecc_dec_arb;

  localparam int unsigned CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [39:0] req0_cw = '0, req1_cw = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_spare, out_src, out_ce, out_ue;
  logic [6:0]  out_syn;
  logic        cnt_clr = 1'b0;
  logic [CNT_W-1:0] ce_cnt, ue_cnt;

  always #5 clk = ~clk;

  ecc_dec_arb #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cw(req0_cw),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cw(req1_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_spare(out_spare), .out_src(out_src), .out_ce(out_ce), .out_ue(out_ue),
    .out_syn(out_syn), .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        spare;
    logic        src;
    logic        ce;
    logic        ue;
    logic [6:0]  syn;
  } res_t;

  res_t exp_q[$];
  res_t mon_got, mon_exp;
  int unsigned checks = 0, errors = 0;

  localparam logic [6:0] COLS [0:31] = '{
    7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
    7'h1A, 7'h70, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A,
    7'h2C, 7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46,
    7'h49, 7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61
  };

  function automatic logic [39:0] enc(input logic [31:0] d, input logic sp);
    logic [6:0] c;
    c = '0;
    for (int j = 0; j < 32; j++) if (d[j]) c = c ^ COLS[j];
    return {sp, c, d};
  endfunction

  function automatic res_t mk(input logic [31:0] d, input logic sp, input logic src,
                              input logic ce, input logic ue, input logic [6:0] syn);
    return {d, sp, src, ce, ue, syn};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_got = {out_data, out_spare, out_src, out_ce, out_ue, out_syn};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got data=%h src=%b ce=%b ue=%b syn=%h expected no output",
                 mon_got.data, mon_got.src, mon_got.ce, mon_got.ue, mon_got.syn);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL out_result: got data=%h sp=%b src=%b ce=%b ue=%b syn=%h expected data=%h sp=%b src=%b ce=%b ue=%b syn=%h",
                   mon_got.data, mon_got.spare, mon_got.src, mon_got.ce, mon_got.ue, mon_got.syn,
                   mon_exp.data, mon_exp.spare, mon_exp.src, mon_exp.ce, mon_exp.ue, mon_exp.syn);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic src, input logic [39:0] cw, input res_t e);
    int unsigned n;
    logic done;
    n = 0;
    done = 1'b0;
    if (src) begin req1_valid = 1'b1; req1_cw = cw; end
    else     begin req0_valid = 1'b1; req0_cw = cw; end
    while (!done && n < 20) begin
      @(negedge clk);
      if (src ? req1_ready : req0_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("send_accepted", done, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [39:0] cw0;
  int unsigned n0, n1, g;
  int unsigned wait_n;

  initial begin
    cw0 = enc(32'hDEADBEEF, 1'b1);
    req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, req0_ready, req1_ready, out_data, out_ce, out_ue, out_syn}, 0);
    chk("reset_counters", {ce_cnt, ue_cnt}, 0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Clean word and its two-cycle latency
    send(0, cw0, mk(32'hDEADBEEF, 1, 0, 0, 0, 7'h00));
    @(negedge clk);
    chk("latency_n1", out_valid, 0);
    @(negedge clk);
    chk("latency_n2", out_valid, 1);
    @(posedge clk); #1;
    drain();

    // Single data-bit errors, double error, check-bit error, spare=0 clean word
    send(0, cw0 ^ 40'h00_0000_0001, mk(32'hDEADBEEF, 1, 0, 1, 0, 7'h07));
    send(1, cw0 ^ 40'h00_0000_0200, mk(32'hDEADBEEF, 1, 1, 1, 0, 7'h70));
    drain();
    chk("ce_cnt_2", ce_cnt, 2);
    send(0, cw0 ^ 40'h00_0000_0201, mk(32'hDEADBCEE, 1, 0, 0, 1, 7'h77));
    send(0, cw0 ^ 40'h01_0000_0000, mk(32'hDEADBEEF, 1, 0, 1, 0, 7'h01));
    send(1, enc(32'h12345678, 1'b0), mk(32'h12345678, 0, 1, 0, 0, 7'h00));
    drain();
    chk("ce_cnt_3", ce_cnt, 3);
    chk("ue_cnt_1", ue_cnt, 1);

    // Both valid: alternate starting at req0
    n0 = 0; n1 = 0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req0_cw = enc(32'h1000_0000 + n0, 1'b0);
      req1_cw = enc(32'h2000_0000 + n1, 1'b1);
      @(negedge clk);
      chk("arb_ready", {req0_ready, req1_ready}, (c % 2 == 0) ? 2'b10 : 2'b01);
      if (c % 2 == 0) begin exp_q.push_back(mk(32'h1000_0000 + n0, 0, 0, 0, 0, 7'h00)); n0++; end
      else            begin exp_q.push_back(mk(32'h2000_0000 + n1, 1, 1, 0, 0, 7'h00)); n1++; end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Only req1 valid: accepted every cycle
    req1_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req1_cw = enc(32'h3000_0000 + c, 1'b0);
      @(negedge clk);
      chk("solo_ready", {req0_ready, req1_ready}, 2'b01);
      exp_q.push_back(mk(32'h3000_0000 + c, 0, 1, 0, 0, 7'h00));
      @(posedge clk); #1;
    end
    req1_valid = 1'b0;
    drain();

    // Backpressure: two words enter, then stall with outputs held
    n0 = 0; n1 = 0;
    out_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      req0_cw = enc(32'h5000_0000 + n0, 1'b0);
      req1_cw = enc(32'h6000_0000 + n1, 1'b0);
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        chk("stall_ready", {req0_ready, req1_ready}, 2'b00);
        chk("stall_hold", {out_valid, out_src, out_data}, {2'b10, 32'h5000_0000});
      end else begin
        g = (c < 2) ? c % 2 : (c - 5) % 2;
        chk("bp_ready", {req0_ready, req1_ready}, (g == 0) ? 2'b10 : 2'b01);
        if (g == 0) begin exp_q.push_back(mk(32'h5000_0000 + n0, 0, 0, 0, 0, 7'h00)); n0++; end
        else        begin exp_q.push_back(mk(32'h6000_0000 + n1, 0, 1, 0, 0, 7'h00)); n1++; end
      end
      @(posedge clk); #1;
      if (c == 4) out_ready = 1'b1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Counter saturation at 4 bits
    for (int k = 0; k < 16; k++)
      send(0, cw0 ^ 40'h00_0000_0001, mk(32'hDEADBEEF, 1, 0, 1, 0, 7'h07));
    drain();
    chk("ce_cnt_sat", ce_cnt, 15);
    chk("ue_cnt_keep", ue_cnt, 1);

    // cnt_clr coinciding with a CE transfer
    out_ready = 1'b0;
    send(0, cw0 ^ 40'h00_0000_0001, mk(32'hDEADBEEF, 1, 0, 1, 0, 7'h07));
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!out_valid && wait_n < 10);
    chk("clr_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_ce_cnt", ce_cnt, 1);
    chk("clr_ue_cnt", ue_cnt, 0);
    drain();

    // Reset mid-stream discards in-flight words
    req0_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req0_cw = enc(32'h7777_0000 + c, 1'b1);
      @(negedge clk);
      exp_q.push_back(mk(32'h7777_0000 + c, 1, 0, 0, 0, 7'h00));
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midreset_outputs", {out_valid, req0_ready, req1_ready, out_data, out_spare, out_src, out_ce, out_ue, out_syn}, 0);
    chk("midreset_counters", {ce_cnt, ue_cnt}, 0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    send(1, enc(32'hCAFEF00D, 1'b1), mk(32'hCAFEF00D, 1, 1, 0, 0, 7'h00));
    drain();
    chk("post_reset_cnt", {ce_cnt, ue_cnt}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
